// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared register indices, FSM state type and count limit for
// the fabric configuration controller.
// Optional feature macro: FPGA_CFG_READBACK_EN (adds the READBACK register).
package fpga_cfg_pkg;

  localparam logic [7:0] CFG_REG_STATUS   = 8'h00;
  localparam logic [7:0] CFG_REG_COUNT    = 8'h01;
  localparam logic [7:0] CFG_REG_DATA     = 8'h02;
  localparam logic [7:0] CFG_REG_READBACK = 8'h03;

  localparam int CFG_MAX_CNT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } cfg_state_t;

  // A column chain segment is one byte wide, so longer counts clamp to 8.
  function automatic logic [3:0] cfg_sat_cnt(input logic [3:0] raw);
    return (raw > 4'(CFG_MAX_CNT)) ? 4'(CFG_MAX_CNT) : raw;
  endfunction

endpackage

// File: rtl/fpga_cfg_col_shifter.sv
// fpga_cfg_col_shifter: one fabric column. Holds the per-write bit count, the
// byte being serialized LSB first, and the chain enable.
// With FPGA_CFG_READBACK_EN defined it also captures the chain tail into rb.
module fpga_cfg_col_shifter
  import fpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_we,
  input  logic [3:0] cnt_wdata,
  input  logic       load,
  input  logic [7:0] load_data,
`ifdef FPGA_CFG_READBACK_EN
  input  logic       cfg_tail,
  output logic [7:0] rb,
`endif
  output logic [3:0] cnt,
  output logic       cfg_en,
  output logic       cfg_bit
);

  logic [7:0] sr;
  logic [3:0] rem;

  assign cfg_bit = cfg_en & sr[0];

  // Bit count for the next DATA write, clamped on write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'(CFG_MAX_CNT);
    end else if (cnt_we) begin
      cnt <= cfg_sat_cnt(cnt_wdata);
    end
  end

  // Serializer: the first bit is presented in the cycle right after load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      rem    <= '0;
      cfg_en <= 1'b0;
    end else if (load) begin
      sr     <= load_data;
      rem    <= cnt;
      cfg_en <= (cnt != 4'd0);
    end else if (cfg_en) begin
      sr  <= {1'b0, sr[7:1]};
      rem <= rem - 4'd1;
      if (rem == 4'd1) begin
        cfg_en <= 1'b0;
      end
    end
  end

`ifdef FPGA_CFG_READBACK_EN
  // Chain tail enters at bit 7 on every shift cycle of this column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb <= '0;
    end else if (cfg_en) begin
      rb <= {cfg_tail, rb[7:1]};
    end
  end
`endif

endmodule

// File: rtl/fpga_cfg_ctrl.sv
// fpga_cfg_ctrl: Wishbone slave that turns DATA writes into per-column serial
// shifts on the fabric config chains. The ack is withheld until the longest
// active column has finished shifting.
// Optional feature macro: FPGA_CFG_READBACK_EN (cfg_tail_i port, reg 0x03).
module fpga_cfg_ctrl
  import fpga_cfg_pkg::*;
#(
  parameter int          MX        = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_adr_i,
`ifdef FPGA_CFG_READBACK_EN
  input  logic [MX-1:0] cfg_tail_i,
`endif
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [MX-1:0] cfg_en_o,
  output logic [MX-1:0] cfg_bit_o,
  output logic          busy_o
);

  cfg_state_t           state;
  logic [3:0]           shift_cnt;
  logic [23:0]          total_bits;
  logic [MX-1:0][3:0]   col_cnt;
`ifdef FPGA_CFG_READBACK_EN
  logic [MX-1:0][7:0]   col_rb;
`endif

  logic       req;
  logic [7:0] reg_idx;
  logic       wr_count;
  logic       wr_data;
  logic       start_shift;
  logic [3:0] max_cnt;
  logic [31:0] rd_data;

  assign reg_idx     = wbs_adr_i[7:0];
  assign req         = (state == ST_IDLE) && wbs_stb_i && wbs_cyc_i &&
                       (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr_count    = req && wbs_we_i && (reg_idx == CFG_REG_COUNT);
  assign wr_data     = req && wbs_we_i && (reg_idx == CFG_REG_DATA);
  assign start_shift = wr_data && (max_cnt != 4'd0);

  // Longest count among lanes enabled by this write; masked lanes do not shift.
  always_comb begin
    max_cnt = '0;
    for (int k = 0; k < MX; k++) begin
      if (wbs_sel_i[k] && (col_cnt[k] > max_cnt)) begin
        max_cnt = col_cnt[k];
      end
    end
  end

  // Read mux; writes and unmapped offsets return zero.
  always_comb begin
    rd_data = '0;
    if (!wbs_we_i) begin
      case (reg_idx)
        CFG_REG_STATUS: rd_data = {total_bits, 7'b0, busy_o};
        CFG_REG_COUNT: begin
          for (int k = 0; k < MX; k++) begin
            rd_data[8*k +: 8] = {4'b0, col_cnt[k]};
          end
        end
`ifdef FPGA_CFG_READBACK_EN
        CFG_REG_READBACK: begin
          for (int k = 0; k < MX; k++) begin
            rd_data[8*k +: 8] = col_rb[k];
          end
        end
`endif
        default: rd_data = '0;
      endcase
    end
  end

  // Transaction FSM: IDLE samples, SHIFT stalls the bus, ACK is the ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      shift_cnt  <= '0;
      total_bits <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (start_shift) begin
              state      <= ST_SHIFT;
              shift_cnt  <= max_cnt;
              busy_o     <= 1'b1;
              total_bits <= total_bits + {20'b0, max_cnt};
            end else begin
              state     <= ST_ACK;
              wbs_ack_o <= wbs_cyc_i;
              wbs_dat_o <= rd_data;
            end
          end
        end
        ST_SHIFT: begin
          if (shift_cnt == 4'd1) begin
            state     <= ST_ACK;
            busy_o    <= 1'b0;
            wbs_ack_o <= wbs_cyc_i;
          end else begin
            shift_cnt <= shift_cnt - 4'd1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < MX; k++) begin : g_col
    fpga_cfg_col_shifter u_col (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .cnt_we    (wr_count & wbs_sel_i[k]),
      .cnt_wdata (wbs_dat_i[8*k +: 4]),
      .load      (start_shift & wbs_sel_i[k]),
      .load_data (wbs_dat_i[8*k +: 8]),
`ifdef FPGA_CFG_READBACK_EN
      .cfg_tail  (cfg_tail_i[k]),
      .rb        (col_rb[k]),
`endif
      .cnt       (col_cnt[k]),
      .cfg_en    (cfg_en_o[k]),
      .cfg_bit   (cfg_bit_o[k])
    );
  end

endmodule

// File: tb/tb_fpga_cfg_ctrl.sv
// tb_fpga_cfg_ctrl: table of bus transactions with hand-derived expectations,
// plus hand-written sequences for bus corner cases and mid-shift reset.
module tb_fpga_cfg_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_w, adr;
  logic        ack;
  logic [31:0] dat_r;
  logic [3:0]  cfg_en, cfg_bit;
  logic        busy;
`ifdef FPGA_CFG_READBACK_EN
  logic [3:0]       tail;
  logic [3:0][7:0]  chain;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    int          exp_lat;
    logic [15:0] exp_en;
    logic [31:0] exp_bits;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] dat;
    int          lat;
    logic [15:0] en;
    logic [31:0] bits;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[24];

  always #5 clk = ~clk;

  fpga_cfg_ctrl #(.MX(4), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_w),
    .wbs_adr_i (adr),
`ifdef FPGA_CFG_READBACK_EN
    .cfg_tail_i(tail),
`endif
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .cfg_en_o  (cfg_en),
    .cfg_bit_o (cfg_bit),
    .busy_o    (busy)
  );

`ifdef FPGA_CFG_READBACK_EN
  // 8-bit chain model per column, advancing only while that column shifts.
  always @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else for (int k = 0; k < 4; k++) if (cfg_en[k]) chain[k] <= {cfg_bit[k], chain[k][7:1]};
  end
  always_comb begin
    tail = '0;
    for (int k = 0; k < 4; k++) tail[k] = chain[k][0];
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string n, input logic [7:0] off, input logic [31:0] d,
                               input logic w, input logic [3:0] s, input logic [31:0] ed,
                               input int l, input logic [15:0] en, input logic [31:0] b);
    vec_t v;
    v.name = n; v.adr = BASE | {24'b0, off}; v.dat = d; v.we = w; v.sel = s;
    v.exp_dat = ed; v.exp_lat = l; v.exp_en = en; v.exp_bits = b;
    return v;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
    adr = a; dat_w = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
  endtask

  task automatic release_bus();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  // Drive one transaction, record enables/bits per column until ack, then score.
  task automatic do_txn(input vec_t v);
    exp_t        e;
    logic        got;
    int          lat;
    logic [31:0] rdat;
    logic [15:0] en_cnt;
    logic [31:0] bits;
    logic [3:0]  c;
    sb_q.push_back('{name: v.name, dat: v.exp_dat, lat: v.exp_lat, en: v.exp_en, bits: v.exp_bits});
    @(negedge clk);
    drive(v.adr, v.dat, v.we, v.sel);
    @(posedge clk);
    got = 1'b0; lat = 0; rdat = '0; en_cnt = '0; bits = '0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (cfg_en[k]) begin
          c = en_cnt[4*k +: 4];
          if (c < 4'd8) bits[8*k + int'(c)] = cfg_bit[k];
          en_cnt[4*k +: 4] = c + 4'd1;
        end
      end
      if (ack) begin
        got = 1'b1; lat = i; rdat = dat_r;
      end
    end
    release_bus();
    e = sb_q.pop_front();
    chk({e.name, "_ack"}, 32'(got), 32'd1);
    chk({e.name, "_lat"}, lat, e.lat);
    chk({e.name, "_dat"}, rdat, e.dat);
    chk({e.name, "_en"}, 32'(en_cnt), 32'(e.en));
    chk({e.name, "_bits"}, bits, e.bits);
  endtask

  initial begin
    int          n_ack, n_en, n_en0;
    logic [3:0]  ack_pat;

    vecs[0]  = mkv("rd_status_rst", 8'h00, 32'h0,         0, 4'hF, 32'h0000_0000, 1, 16'h0000, 32'h0);
    vecs[1]  = mkv("rd_count_rst",  8'h01, 32'h0,         0, 4'hF, 32'h0808_0808, 1, 16'h0000, 32'h0);
    vecs[2]  = mkv("wr_count_8",    8'h01, 32'h0808_0808, 1, 4'hF, 32'h0,         1, 16'h0000, 32'h0);
    vecs[3]  = mkv("data_a5c3",     8'h02, 32'hA5C3_0F81, 1, 4'hF, 32'h0,         9, 16'h8888, 32'hA5C3_0F81);
    vecs[4]  = mkv("rd_status_8",   8'h00, 32'h0,         0, 4'hF, 32'h0000_0800, 1, 16'h0000, 32'h0);
    vecs[5]  = mkv("wr_count_mix",  8'h01, 32'h0003_0508, 1, 4'hF, 32'h0,         1, 16'h0000, 32'h0);
    vecs[6]  = mkv("rd_count_mix",  8'h01, 32'h0,         0, 4'hF, 32'h0003_0508, 1, 16'h0000, 32'h0);
    vecs[7]  = mkv("data_ff_mix",   8'h02, 32'hFFFF_FFFF, 1, 4'hF, 32'h0,         9, 16'h0358, 32'h0007_1FFF);
    vecs[8]  = mkv("rd_status_16",  8'h00, 32'h0,         0, 4'hF, 32'h0000_1000, 1, 16'h0000, 32'h0);
    vecs[9]  = mkv("wr_count_sat",  8'h01, 32'h0F0F_0F0F, 1, 4'hF, 32'h0,         1, 16'h0000, 32'h0);
    vecs[10] = mkv("rd_count_sat",  8'h01, 32'h0,         0, 4'hF, 32'h0808_0808, 1, 16'h0000, 32'h0);
    vecs[11] = mkv("data_lane1",    8'h02, 32'hFFFF_3CFF, 1, 4'h2, 32'h0,         9, 16'h0080, 32'h0000_3C00);
    vecs[12] = mkv("wr_count_l1_0", 8'h01, 32'hFFFF_00FF, 1, 4'h2, 32'h0,         1, 16'h0000, 32'h0);
    vecs[13] = mkv("data_l1_zero",  8'h02, 32'hFFFF_FFFF, 1, 4'h2, 32'h0,         1, 16'h0000, 32'h0);
    vecs[14] = mkv("rd_status_24",  8'h00, 32'h0,         0, 4'hF, 32'h0000_1800, 1, 16'h0000, 32'h0);
    vecs[15] = mkv("rd_data_reg",   8'h02, 32'h0,         0, 4'hF, 32'h0,         1, 16'h0000, 32'h0);
    vecs[16] = mkv("rd_unmapped",   8'h10, 32'h0,         0, 4'hF, 32'h0,         1, 16'h0000, 32'h0);
    vecs[17] = mkv("wr_unmapped",   8'h05, 32'hFFFF_FFFF, 1, 4'hF, 32'h0,         1, 16'h0000, 32'h0);
    vecs[18] = mkv("rd_count_keep", 8'h01, 32'h0,         0, 4'hF, 32'h0808_0008, 1, 16'h0000, 32'h0);
    vecs[19] = mkv("wr_count_l0_3", 8'h01, 32'hFFFF_FF03, 1, 4'h1, 32'h0,         1, 16'h0000, 32'h0);
    vecs[20] = mkv("rd_count_l0",   8'h01, 32'h0,         0, 4'hF, 32'h0808_0003, 1, 16'h0000, 32'h0);
    vecs[21] = mkv("data_mixed",    8'h02, 32'h1234_5678, 1, 4'hF, 32'h0,         9, 16'h8803, 32'h1234_0000);
    vecs[22] = mkv("wr_status_ro",  8'h00, 32'hFFFF_FFFF, 1, 4'hF, 32'h0,         1, 16'h0000, 32'h0);
    vecs[23] = mkv("rd_status_32",  8'h00, 32'h0,         0, 4'hF, 32'h0000_2000, 1, 16'h0000, 32'h0);

    rst = 1'b1;
    release_bus();
    adr = '0; dat_w = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {27'b0, ack, cfg_en}, 32'h0);
    chk("rst_busy_bits", {27'b0, busy, cfg_bit}, 32'h0);
    chk("rst_dat", dat_r, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) do_txn(vecs[i]);

    // Non-matching base (low byte decodes as DATA): never acked, nothing shifts.
    @(negedge clk);
    drive(32'h3000_0102, 32'hFFFF_FFFF, 1'b1, 4'hF);
    n_ack = 0; n_en = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack) n_ack++;
      if (cfg_en != 4'h0) n_en++;
    end
    release_bus();
    chk("nomatch_ack", n_ack, 0);
    chk("nomatch_en", n_en, 0);

    // stb/cyc held after ack: second sample only after returning to IDLE.
    @(negedge clk);
    drive(BASE, 32'h0, 1'b0, 4'hF);
    @(posedge clk);
    ack_pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_pat[i] = ack;
      if (i == 0) chk("held_dat", dat_r, 32'h0000_2000);
    end
    release_bus();
    chk("held_ack_pattern", 32'(ack_pat), 32'h5);

    // cyc dropped mid-shift: shift finishes, no ack, total still advances.
    do_txn(mkv("wr_count_all8", 8'h01, 32'h0808_0808, 1, 4'hF, 32'h0, 1, 16'h0000, 32'h0));
    @(negedge clk);
    drive(BASE | 32'h2, 32'hFFFF_FFFF, 1'b1, 4'hF);
    @(posedge clk);
    n_ack = 0; n_en0 = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_in_shift", 32'(busy), 32'd1);
      if (i == 3) release_bus();
      if (ack) n_ack++;
      if (cfg_en[0]) n_en0++;
    end
    chk("cycdrop_ack", n_ack, 0);
    chk("cycdrop_en_cycles", n_en0, 8);
    chk("cycdrop_busy_end", 32'(busy), 32'd0);
    do_txn(mkv("rd_status_40", 8'h00, 32'h0, 0, 4'hF, 32'h0000_2800, 1, 16'h0000, 32'h0));

    // Reset after four shift cycles clears outputs immediately.
    @(negedge clk);
    drive(BASE | 32'h2, 32'hA5A5_A5A5, 1'b1, 4'hF);
    @(posedge clk);
    n_en0 = 0; n_ack = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (cfg_en[0]) n_en0++;
      if (ack) n_ack++;
    end
    chk("rstmid_en_before", n_en0, 4);
    rst = 1'b1;
    #1;
    chk("rstmid_outputs", {27'b0, ack, cfg_en}, 32'h0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    release_bus();
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_no_ack", n_ack, 0);
    do_txn(mkv("rd_count_after_rst",  8'h01, 32'h0, 0, 4'hF, 32'h0808_0808, 1, 16'h0000, 32'h0));
    do_txn(mkv("rd_status_after_rst", 8'h00, 32'h0, 0, 4'hF, 32'h0,         1, 16'h0000, 32'h0));
    do_txn(mkv("data_after_rst",      8'h02, 32'hC3C3_C3C3, 1, 4'hF, 32'h0, 9, 16'h8888, 32'hC3C3_C3C3));

`ifdef FPGA_CFG_READBACK_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_txn(mkv("rb_data_1", 8'h02, 32'h5A5A_5A5A, 1, 4'hF, 32'h0, 9, 16'h8888, 32'h5A5A_5A5A));
    do_txn(mkv("rb_data_2", 8'h02, 32'h5A5A_5A5A, 1, 4'hF, 32'h0, 9, 16'h8888, 32'h5A5A_5A5A));
    do_txn(mkv("rb_read",   8'h03, 32'h0, 0, 4'hF, 32'h5A5A_5A5A, 1, 16'h0000, 32'h0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
